// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-back, write-allocate data cache
//               controller for the MEM stage. One 32-bit word per line,
//               byte-strobed stores. A miss raises CacheStall in the same
//               cycle, optionally writes back the dirty victim, refills the
//               line, and then lets the frozen access replay as a hit.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   MemReadM        : MEM-stage load
//   MemWriteM       : MEM-stage store (never together with MemReadM)
//   AddrM           : byte address (offset bits ignored)
//   WriteDataM      : lane-aligned store data
//   ByteEnM         : store byte strobes
//   ReadDataM       : load word, combinational on hit
//   CacheStall      : pipeline freeze request
//   mem_req/mem_we  : memory request / 1 = victim write-back, 0 = refill
//   mem_addr        : word-aligned memory address
//   mem_wdata       : victim data
//   mem_rdata       : refill data
//   mem_ready       : one-cycle acceptance/completion pulse
// ============================================================================
module dcache_ctrl #(
  parameter int SETS   = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] AddrM,
  input  logic [31:0]       WriteDataM,
  input  logic [3:0]        ByteEnM,
  output logic [31:0]       ReadDataM,
  output logic              CacheStall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - IW - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [SETS-1:0] r_valid;
  logic [SETS-1:0] r_dirty;
  logic [TW-1:0]   r_tag  [SETS];
  logic [31:0]     r_data [SETS];

  logic [IW-1:0]   w_index;
  logic [TW-1:0]   w_tag;
  logic            w_access;
  logic            w_hit;
  logic [31:0]     w_line;
  logic [31:0]     w_merged;
  logic            w_store_hit;
  logic            w_refill_done;

  assign w_index  = AddrM[IW+1:2];
  assign w_tag    = AddrM[ADDR_W-1:IW+2];
  assign w_access = MemReadM | MemWriteM;
  assign w_hit    = w_access & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_line   = r_data[w_index];

  // Only an IDLE-state hit commits a store; the replayed access after a
  // refill lands here too, which is how write-allocate merges its data.
  assign w_store_hit   = (r_state == S_IDLE) & w_hit & MemWriteM;
  assign w_refill_done = (r_state == S_REFILL) & mem_ready;

  always_comb begin
    w_merged = w_line;
    for (int b = 0; b < 4; b++) begin
      if (ByteEnM[b]) begin
        w_merged[8*b +: 8] = WriteDataM[8*b +: 8];
      end
    end
  end

  assign ReadDataM  = rst ? 32'd0 : w_line;
  assign CacheStall = (r_state != S_IDLE) | (w_access & ~w_hit);
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = w_line;

  // AddrM is held by the frozen pipeline, so the index (and hence the victim
  // tag/data) stays stable for the whole transaction.
  always_comb begin
    if (r_state == S_WB) begin
      mem_addr = {r_tag[w_index], w_index, 2'b00};
    end else begin
      mem_addr = {AddrM[ADDR_W-1:2], 2'b00};
    end
  end

  // Control FSM plus valid/dirty bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_valid   <= '0;
      r_dirty   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_store_hit) begin
            r_dirty[w_index] <= 1'b1;
          end
          if (w_access & ~w_hit) begin
            r_mem_req <= 1'b1;
            if (r_valid[w_index] & r_dirty[w_index]) begin
              r_state  <= S_WB;
              r_mem_we <= 1'b1;
            end else begin
              r_state  <= S_REFILL;
              r_mem_we <= 1'b0;
            end
          end
        end
        S_WB: begin
          if (mem_ready) begin
            r_dirty[w_index] <= 1'b0;
            r_state          <= S_REFILL;
            r_mem_we         <= 1'b0;
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
            r_state          <= S_IDLE;
            r_mem_req        <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_refill_done) begin
        r_tag[w_index]  <= w_tag;
        r_data[w_index] <= mem_rdata;
      end else if (w_store_hit) begin
        r_data[w_index] <= w_merged;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl: directed vector table,
//               reset-abort sequence, and randomized accesses against a
//               word-level cache/memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] AddrM = '0;
  logic [31:0] WriteDataM = '0;
  logic [3:0]  ByteEnM = '0;
  logic [31:0] ReadDataM;
  logic        CacheStall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  dcache_ctrl #(.SETS(256), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .AddrM(AddrM),
    .WriteDataM(WriteDataM), .ByteEnM(ByteEnM), .ReadDataM(ReadDataM),
    .CacheStall(CacheStall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- main memory seen by the DUT ----------------
  logic [31:0] mem [logic [29:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'hA5A5_A5A5;
  endfunction

  // ---------------- reference model ----------------
  // Each line remembers the full word address it caches.
  logic [31:0] ref_mem [logic [29:0]];
  bit          m_valid [256];
  bit          m_dirty [256];
  logic [31:0] m_addr  [256];
  logic [31:0] m_word  [256];
  int          e_n;
  logic [31:0] e_addr [4];
  bit          e_we   [4];
  logic [31:0] e_wd   [4];
  int          e_stalls;
  logic [31:0] e_rdata;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'hA5A5_A5A5;
  endfunction

  function automatic void model(input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be,
                                input int lat);
    int          i;
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    i  = int'((a >> 2) % 256);
    e_n = 0;
    e_stalls = 0;
    if (!(m_valid[i] && m_addr[i] == wa)) begin
      e_stalls = 1;
      if (m_valid[i] && m_dirty[i]) begin
        e_addr[e_n] = m_addr[i]; e_we[e_n] = 1; e_wd[e_n] = m_word[i];
        ref_mem[m_addr[i][31:2]] = m_word[i];
        e_n++;
        e_stalls += lat + 1;
      end
      e_addr[e_n] = wa; e_we[e_n] = 0; e_wd[e_n] = '0;
      e_n++;
      e_stalls += lat + 1;
      m_valid[i] = 1; m_dirty[i] = 0; m_addr[i] = wa; m_word[i] = ref_rd(wa);
    end
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_word[i][8*b +: 8] = wd[8*b +: 8];
      m_dirty[i] = 1;
    end
    e_rdata = m_word[i];
  endfunction

  // ---------------- access driver + memory responder ----------------
  logic [31:0] t_addr [4];
  bit          t_we   [4];
  logic [31:0] t_wd   [4];

  // Entered and left at posedge+1. Returns the hit-cycle read data, the
  // number of stalled cycles and the number of completed transactions.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           input int lat, output logic [31:0] rdata,
                           output int stalls, output int nreq);
    int          wait_cnt;
    bit          done;
    logic [31:0] p_addr, p_wd;
    logic        p_we;
    MemReadM = rd; MemWriteM = wr; AddrM = a; WriteDataM = wd; ByteEnM = be;
    stalls = 0; nreq = 0; wait_cnt = 0; done = 0; rdata = '0;
    p_addr = '0; p_wd = '0; p_we = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      if (!CacheStall) begin
        rdata = ReadDataM;
        done = 1;
      end else begin
        stalls++;
        if (mem_req) begin
          if (wait_cnt > 0) begin
            chk("hold_addr", mem_addr, p_addr);
            chk("hold_we", {31'd0, mem_we}, {31'd0, p_we});
            if (mem_we) chk("hold_wdata", mem_wdata, p_wd);
          end
          p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
          if (wait_cnt == lat) begin
            if (nreq < 4) begin
              t_addr[nreq] = mem_addr; t_we[nreq] = mem_we; t_wd[nreq] = mem_wdata;
            end
            nreq++;
            mem_ready = 1'b1;
            if (mem_we) mem[mem_addr[31:2]] = mem_wdata;
            else        mem_rdata = mem_rd(mem_addr);
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout: stall never released for addr %h", a);
    end
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  // Transactions observed versus the model's expected list.
  task automatic chk_trans(input int nreq);
    chk("req_count", nreq, e_n);
    for (int k = 0; k < 4; k++) begin
      if (k < nreq && k < e_n) begin
        chk("req_addr", t_addr[k], e_addr[k]);
        chk("req_we", {31'd0, t_we[k]}, {31'd0, e_we[k]});
        if (e_we[k]) chk("req_wdata", t_wd[k], e_wd[k]);
      end
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    int          lat;
    logic [31:0] erd;
    int          est;
    int          en;
    logic [31:0] ea0;
    bit          ewe0;
    logic [31:0] ewd0;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [31:0] rdata;
    int          stalls, nreq;

    tbl[0]  = '{1, 0, 32'h0000_0100, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 5, 1, 32'h0000_0100, 0, 32'h0};
    tbl[1]  = '{0, 1, 32'h0000_0100, 32'h0000_AA00, 4'b0010, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0};
    tbl[2]  = '{1, 0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'hDEAD_AAEF, 0, 0, 32'h0, 0, 32'h0};
    tbl[3]  = '{1, 0, 32'h0000_0500, 32'h0, 4'h0, 2, 32'h1111_1111, 7, 2, 32'h0000_0100, 1, 32'hDEAD_AAEF};
    tbl[4]  = '{0, 1, 32'h0000_0204, 32'h1234_5678, 4'hF, 1, 32'h0, 3, 1, 32'h0000_0204, 0, 32'h0};
    tbl[5]  = '{1, 0, 32'h0000_0204, 32'h0, 4'h0, 0, 32'h1234_5678, 0, 0, 32'h0, 0, 32'h0};
    tbl[6]  = '{0, 1, 32'h0000_0206, 32'hAABB_0000, 4'b1100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0};
    tbl[7]  = '{1, 0, 32'h0000_0204, 32'h0, 4'h0, 0, 32'hAABB_5678, 0, 0, 32'h0, 0, 32'h0};
    tbl[8]  = '{1, 0, 32'h0000_0A04, 32'h0, 4'h0, 1, 32'hA5A5_AFA1, 5, 2, 32'h0000_0204, 1, 32'hAABB_5678};
    tbl[9]  = '{1, 0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'hDEAD_AAEF, 2, 1, 32'h0000_0100, 0, 32'h0};
    tbl[10] = '{1, 0, 32'h0000_0300, 32'h0, 4'h0, 10, 32'hA5A5_A6A5, 12, 1, 32'h0000_0300, 0, 32'h0};
    tbl[11] = '{1, 0, 32'hFFFF_F100, 32'h0, 4'h0, 1, 32'h5A5A_54A5, 3, 1, 32'hFFFF_F100, 0, 32'h0};
    tbl[12] = '{1, 0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'hDEAD_AAEF, 3, 1, 32'h0000_0100, 0, 32'h0};
    tbl[13] = '{1, 0, 32'h0000_0204, 32'h0, 4'h0, 0, 32'hAABB_5678, 2, 1, 32'h0000_0204, 0, 32'h0};

    mem[30'h40]     = 32'hDEAD_BEEF;  ref_mem[30'h40]  = 32'hDEAD_BEEF;
    mem[30'h140]    = 32'h1111_1111;  ref_mem[30'h140] = 32'h1111_1111;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_stall", {31'd0, CacheStall}, 32'h0);
    chk("rst_req", {31'd0, mem_req}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req", {31'd0, mem_req}, 32'h0);
    chk("post_rst_stall", {31'd0, CacheStall}, 32'h0);

    // Directed vector table.
    for (int v = 0; v < 14; v++) begin
      model(tbl[v].wr, tbl[v].addr, tbl[v].wd, tbl[v].be, tbl[v].lat);
      do_access(tbl[v].rd, tbl[v].wr, tbl[v].addr, tbl[v].wd, tbl[v].be,
                tbl[v].lat, rdata, stalls, nreq);
      if (tbl[v].rd) chk($sformatf("tbl%0d_rdata", v), rdata, tbl[v].erd);
      chk($sformatf("tbl%0d_stalls", v), stalls, tbl[v].est);
      chk($sformatf("tbl%0d_nreq", v), nreq, tbl[v].en);
      if (tbl[v].en > 0 && nreq > 0) begin
        chk($sformatf("tbl%0d_addr0", v), t_addr[0], tbl[v].ea0);
        chk($sformatf("tbl%0d_we0", v), {31'd0, t_we[0]}, {31'd0, tbl[v].ewe0});
        if (tbl[v].ewe0) chk($sformatf("tbl%0d_wd0", v), t_wd[0], tbl[v].ewd0);
      end
      chk_trans(nreq);
    end

    // Idle cycle: nothing requested.
    #1;
    chk("idle_stall", {31'd0, CacheStall}, 32'h0);
    chk("idle_req", {31'd0, mem_req}, 32'h0);
    @(posedge clk); #1;

    // Reset two cycles into a refill abandons it.
    MemReadM = 1'b1; AddrM = 32'h0000_0700;
    #1;
    chk("abort_miss_stall", {31'd0, CacheStall}, 32'h1);
    chk("abort_miss_req", {31'd0, mem_req}, 32'h0);
    @(posedge clk); #1;
    chk("abort_refill_req", {31'd0, mem_req}, 32'h1);
    chk("abort_refill_addr", mem_addr, 32'h0000_0700);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_rst_rdata", ReadDataM, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; MemReadM = 1'b0;
    #1;
    chk("abort_after_req", {31'd0, mem_req}, 32'h0);
    chk("abort_after_stall", {31'd0, CacheStall}, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0;
    end
    model(0, 32'h0000_0100, 32'h0, 4'h0, 1);
    do_access(1, 0, 32'h0000_0100, 32'h0, 4'h0, 1, rdata, stalls, nreq);
    chk("post_abort_nreq", nreq, 32'd1);
    if (nreq > 0) chk("post_abort_addr", t_addr[0], 32'h0000_0100);
    chk("post_abort_rdata", rdata, 32'hDEAD_AAEF);
    chk_trans(nreq);

    // Randomized accesses on a few conflicting indices.
    for (int r = 0; r < 300; r++) begin
      logic [31:0] a, wd;
      logic [3:0]  be;
      logic [21:0] tg;
      logic [7:0]  ix;
      bit          wr;
      int          lat;
      tg  = ($urandom_range(0, 4) == 0) ? 22'($urandom) : 22'($urandom_range(0, 3));
      ix  = 8'h10 + 8'($urandom_range(0, 1));
      a   = {tg, ix, 2'($urandom)};
      wr  = $urandom_range(0, 1) == 1;
      wd  = $urandom;
      be  = 4'($urandom);
      lat = $urandom_range(0, 3);
      model(wr, a, wd, be, lat);
      do_access(!wr, wr, a, wd, be, lat, rdata, stalls, nreq);
      if (!wr) chk("rnd_rdata", rdata, e_rdata);
      chk("rnd_stalls", stalls, e_stalls);
      chk_trans(nreq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
